// File: rtl/rec_play_ctrl_if.sv
// Transport-control bundle between the button/strobe sources and rec_play_ctrl.
// The master drives buttons and sample strobes; the slave returns address, mode and take status.
interface rec_play_ctrl_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              play_btn;
  logic              record_btn;
  logic              stop_btn;
  logic              sample_wr;
  logic              sample_rd;
  logic [ADDR_W-1:0] addr;
  logic              record;
  logic              play;
  logic              paused;
  logic [ADDR_W:0]   rec_len;
  logic              full;
  logic [1:0]        state_o;

  modport master (
    output play_btn, record_btn, stop_btn, sample_wr, sample_rd,
    input  addr, record, play, paused, rec_len, full, state_o
  );

  modport slave (
    input  play_btn, record_btn, stop_btn, sample_wr, sample_rd,
    output addr, record, play, paused, rec_len, full, state_o
  );
endinterface

// File: rtl/rec_play_ctrl.sv
// Record/play transport controller: edge-detects buttons and sample strobes,
// owns the SRAM sample address and remembers the length of the last take.
module rec_play_ctrl #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned MAX_LEN = 262144,
  parameter bit          LOOP    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  rec_play_ctrl_if.slave   bus
);
  localparam int unsigned LEN_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECORD = 2'd1;
  localparam logic [1:0] S_PLAY   = 2'd2;
  localparam logic [1:0] S_PAUSE  = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rec_len;
  logic              r_full;
  logic              r_record;
  logic              r_play;
  logic              r_paused;
  logic [4:0]        r_prev;

  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [LEN_W-1:0]  w_rec_len_nxt;
  logic              w_full_nxt;
  logic [4:0]        w_in;
  logic [4:0]        w_rise;
  logic              w_stop_ev;
  logic              w_rec_ev;
  logic              w_play_ev;
  logic              w_wr_ev;
  logic              w_rd_ev;
  logic [ADDR_W-1:0] w_addr_inc;

  assign w_in = {bus.stop_btn, bus.record_btn, bus.play_btn, bus.sample_wr, bus.sample_rd};
  assign w_rise = w_in & ~r_prev;

  // Only the highest-priority button event acts: stop > record > play.
  assign w_stop_ev  = w_rise[4];
  assign w_rec_ev   = w_rise[3] & ~w_rise[4];
  assign w_play_ev  = w_rise[2] & ~w_rise[3] & ~w_rise[4];
  assign w_wr_ev    = w_rise[1];
  assign w_rd_ev    = w_rise[0];
  assign w_addr_inc = r_addr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_rec_len <= '0;
      r_full    <= 1'b0;
      r_record  <= 1'b0;
      r_play    <= 1'b0;
      r_paused  <= 1'b0;
      r_prev    <= 5'b11111;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_rec_len <= w_rec_len_nxt;
      r_full    <= w_full_nxt;
      r_record  <= (w_state_nxt == S_RECORD);
      r_play    <= (w_state_nxt == S_PLAY);
      r_paused  <= (w_state_nxt == S_PAUSE);
      r_prev    <= w_in;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_rec_len_nxt = r_rec_len;
    w_full_nxt    = r_full;
    case (r_state)
      S_IDLE: begin
        if (w_stop_ev) begin
          w_addr_nxt = '0;
        end else if (w_rec_ev) begin
          w_state_nxt = S_RECORD;
          w_addr_nxt  = '0;
          w_full_nxt  = 1'b0;
        end else if (w_play_ev && (r_rec_len != '0)) begin
          w_state_nxt = S_PLAY;
          w_addr_nxt  = '0;
        end
      end
      S_RECORD: begin
        // A sample landing with stop/record is counted before the take closes.
        if (w_wr_ev && (r_addr == ADDR_W'(MAX_LEN - 1))) begin
          w_state_nxt   = S_IDLE;
          w_addr_nxt    = '0;
          w_rec_len_nxt = LEN_W'(MAX_LEN);
          w_full_nxt    = 1'b1;
        end else if (w_stop_ev || w_rec_ev) begin
          w_state_nxt   = S_IDLE;
          w_addr_nxt    = '0;
          w_rec_len_nxt = LEN_W'(r_addr) + LEN_W'(w_wr_ev);
        end else if (w_wr_ev) begin
          w_addr_nxt = w_addr_inc;
        end
      end
      S_PLAY: begin
        if (w_stop_ev) begin
          w_state_nxt = S_IDLE;
          w_addr_nxt  = '0;
        end else if (w_play_ev) begin
          w_state_nxt = S_PAUSE;
        end else if (w_rd_ev) begin
          if ({1'b0, r_addr} == (r_rec_len - LEN_W'(1))) begin
            w_addr_nxt = '0;
            if (!LOOP) w_state_nxt = S_IDLE;
          end else begin
            w_addr_nxt = w_addr_inc;
          end
        end
      end
      default: begin
        if (w_stop_ev) begin
          w_state_nxt = S_IDLE;
          w_addr_nxt  = '0;
        end else if (w_play_ev) begin
          w_state_nxt = S_PLAY;
        end
      end
    endcase
  end

  assign bus.addr    = r_addr;
  assign bus.record  = r_record;
  assign bus.play    = r_play;
  assign bus.paused  = r_paused;
  assign bus.rec_len = r_rec_len;
  assign bus.full    = r_full;
  assign bus.state_o = r_state;
endmodule

// File: doc/rec_play_ctrl.md
Name: rec_play_ctrl

Overview:
- Transport controller sitting directly upstream of the SRAM controller and the ADC/DAC serial stages in the recorder datapath.
- Turns debounced play/record/stop button levels into the record and play mode strobes, and owns the single SRAM sample address.
- Advances the address on per-sample handshake pulses and remembers the recorded length, so playback stops or loops at the end of the recorded take.

Parameters:
- ADDR_W, 18, SRAM word-address width.
- MAX_LEN, 262144, maximum samples per take (must be <= 2**ADDR_W).
- LOOP, 0, 1 = playback wraps to address 0 at end of take; 0 = return to IDLE.

Ports:
- clk  in  1  system clock (12 MHz PLL output)
- reset  in  1  synchronous, active-high reset
- play_btn  in  1  debounced play/pause button level, active high
- record_btn  in  1  debounced record button level, active high
- stop_btn  in  1  debounced stop button level, active high
- sample_wr  in  1  ADC-side "sample written" strobe, synchronous to clk, may be high for several cycles
- sample_rd  in  1  DAC-side "sample consumed" strobe, same rules as sample_wr
- addr  out  ADDR_W  current SRAM word address
- record  out  1  high while in RECORD
- play  out  1  high while in PLAY
- paused  out  1  high while in PAUSE
- rec_len  out  ADDR_W+1  number of samples in the last completed/aborted take
- full  out  1  sticky: last take ended by hitting MAX_LEN
- state_o  out  2  debug state code: IDLE=0, RECORD=1, PLAY=2, PAUSE=3

Behaviour:
- All outputs are registered. Reset values: state IDLE, addr=0, record=0, play=0, paused=0, rec_len=0, full=0.
- Edge detection:
  - Each of the five inputs has a prev register.
  - An event is input=1 with prev=0.
  - All prev registers reset to 1, so a button or strobe already held high through reset produces no event.
  - A level held high counts once.
- Latency: an event sampled on cycle n updates state and outputs on cycle n+1.
- Button priority on the same cycle: stop > record > play. Only the highest-priority button event acts.
- IDLE:
  - record event -> RECORD; addr=0, full=0.
  - play event with rec_len != 0 -> PLAY; addr=0.
  - play event with rec_len = 0 -> stay IDLE.
  - stop event -> stay IDLE; addr=0.
- RECORD:
  - sample_wr event -> addr+1.
  - If the written sample was number MAX_LEN (addr = MAX_LEN-1) -> IDLE; rec_len=MAX_LEN, full=1, addr=0.
  - stop or record event -> IDLE; rec_len=addr (samples written so far, 0 allowed), addr=0.
  - A sample_wr event on the same cycle as stop/record is counted first: rec_len=addr+1.
  - play events are ignored.
- PLAY:
  - sample_rd event -> addr+1.
  - When addr = rec_len-1 and sample_rd fires: LOOP=1 -> addr=0, stay in PLAY; LOOP=0 -> IDLE, addr=0.
  - play event -> PAUSE; addr held.
  - stop event -> IDLE; addr=0.
  - record events are ignored.
- PAUSE:
  - sample_rd events are ignored; addr frozen.
  - play event -> PLAY, resuming at the same addr.
  - stop event -> IDLE; addr=0.
  - record events are ignored.
- Strobe gating: sample_wr events outside RECORD and sample_rd events outside PLAY never move addr. Their prev registers still track the inputs.
- Mode outputs: record, play and paused are one-hot decodes of state, with at most one high; all low in IDLE.
- rec_len is unchanged by playback. It changes only on RECORD exit.
- Reset mid-operation: everything returns to reset values on the next edge, including rec_len=0 (the take is lost).
- Width: addr increments modulo 2**ADDR_W, but the MAX_LEN terminal condition always fires first. rec_len is one bit wider than addr so that MAX_LEN = 2**ADDR_W is representable.

Test Plan:
- Reset with record_btn held high, then release and press record -> no action during the hold; first real press enters RECORD (state_o=1, record=1) one cycle after the edge.
- Record 5 sample_wr pulses (each 3 cycles wide), then stop -> addr steps 0..5 once per pulse; on stop rec_len=5, addr=0, state IDLE.
- Play with rec_len=5, LOOP=0, 5 sample_rd pulses -> addr 0,1,2,3,4, then IDLE with addr=0. With LOOP=1 the 5th pulse gives addr=0 and play stays 1.
- Pause/resume: in PLAY at addr=2, press play -> paused=1; 3 sample_rd pulses leave addr=2; press play -> PLAY at addr=2; next pulse -> addr=3.
- Full: MAX_LEN=8, record 8 pulses -> after the 8th, state IDLE, rec_len=8, full=1. A new record press clears full to 0.
- Simultaneous events: stop and record on the same cycle in IDLE -> stays IDLE. sample_wr and stop on the same cycle at addr=3 in RECORD -> rec_len=4. Play press in IDLE with rec_len=0 -> stays IDLE.
